monster_dir_ctrl: RTL and testbench

//  Per-ghost direction scheduler: drives the 2-bit direction key of one monster movement block.

---
 rtl/monster_ctrl_pkg.sv | 26 ++
 rtl/monster_lfsr.sv | 25 ++
 rtl/monster_dir_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_monster_dir_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/monster_ctrl_pkg.sv
// Shared types and helpers for the monster direction scheduler.
package monster_ctrl_pkg;

    localparam int DIR_W   = 2;
    localparam int COORD_W = 11;

    typedef enum logic [DIR_W-1:0] {
        UP    = 2'b00,
        DOWN  = 2'b01,
        RIGHT = 2'b10,
        LEFT  = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SCATTER = 2'b01,
        CHASE   = 2'b10,
        FRIGHT  = 2'b11
    } mode_t;

    // Opposite direction on the same axis.
    function automatic dir_t reverse(input dir_t d);
        return dir_t'({d[1], ~d[0]});
    endfunction

endpackage

// File: rtl/monster_lfsr.sv
// 8-bit Galois LFSR, polynomial x^8+x^6+x^5+x^4+1, stepping when i_step is high.
module monster_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       i_step,
    output logic [7:0] o_state
);

    localparam logic [7:0] TAPS = 8'hB8;

    logic [7:0] r_state;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= SEED;
        end else if (i_step) begin
            r_state <= (r_state >> 1) ^ (r_state[0] ? TAPS : 8'h00);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/monster_dir_ctrl.sv
// Per-ghost direction scheduler: SCATTER/CHASE mode timers plus one direction decision per frame.
// Define GHOST_FRIGHT_EN to build FRIGHT mode, power-pill handling and the random source.
module monster_dir_ctrl
    import monster_ctrl_pkg::*;
#(
    parameter int         SCATTER_X      = 40,
    parameter int         SCATTER_Y      = 40,
    parameter int         SCATTER_FRAMES = 210,
    parameter int         CHASE_FRAMES   = 600,
    parameter int         FRIGHT_FRAMES  = 180,
    parameter int         HOLD_FRAMES    = 8,
    parameter logic [1:0] INIT_DIR       = 2'b11,
    parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      startOfFrame,
    input  logic                      enable,
    input  logic                      collision,
    input  logic                      powerPill,
    input  logic signed [COORD_W-1:0] pacmanX,
    input  logic signed [COORD_W-1:0] pacmanY,
    input  logic signed [COORD_W-1:0] monsterX,
    input  logic signed [COORD_W-1:0] monsterY,
    output logic [DIR_W-1:0]          direction_key,
    output logic [1:0]                mode,
    output logic                      frightened
);

    localparam int                  CNT_W     = 16;
    localparam logic [7:0]          HOLD_LOAD = 8'(HOLD_FRAMES - 1);
    localparam logic [COORD_W:0]    SC_X      = (COORD_W + 1)'(SCATTER_X);
    localparam logic [COORD_W:0]    SC_Y      = (COORD_W + 1)'(SCATTER_Y);

    typedef enum logic {DEC_WAIT, DEC_DECIDE} dec_state_t;

    mode_t            r_mode;
    logic [CNT_W-1:0] r_phase_cnt;
    dec_state_t       r_dec_state;
    dir_t             r_dir;
    logic [7:0]       r_hold;
    logic             r_coll;

    logic [COORD_W:0] w_tx, w_ty, w_dx, w_dy, w_adx, w_ady;
    dir_t             w_x_dir, w_y_dir, w_pri, w_sec, w_next_dir;

`ifdef GHOST_FRIGHT_EN
    mode_t            r_saved_mode;
    logic [CNT_W-1:0] r_saved_cnt;
    logic [CNT_W-1:0] r_fright_cnt;
    logic             r_frightened;
    logic [7:0]       w_lfsr;
    logic             w_unused_lfsr_hi;

    monster_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .resetN  (resetN),
        .i_step  (startOfFrame && enable),
        .o_state (w_lfsr)
    );

    assign w_unused_lfsr_hi = ^w_lfsr[7:2];
    assign frightened       = r_frightened;
`else
    localparam int         unused_fright_frames = FRIGHT_FRAMES;
    localparam logic [7:0] unused_lfsr_seed     = LFSR_SEED;
    logic                  w_unused_pill;

    assign w_unused_pill = powerPill;
    assign frightened    = 1'b0;
`endif

    // Mode FSM: a pill wins over a coincident frame pulse, which then goes uncounted.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_mode      <= IDLE;
            r_phase_cnt <= '0;
`ifdef GHOST_FRIGHT_EN
            r_saved_mode <= IDLE;
            r_saved_cnt  <= '0;
            r_fright_cnt <= '0;
            r_frightened <= 1'b0;
`endif
        end
`ifdef GHOST_FRIGHT_EN
        else if (enable && powerPill && r_mode != IDLE) begin
            r_fright_cnt <= CNT_W'(FRIGHT_FRAMES);
            r_frightened <= 1'b1;
            if (r_mode != FRIGHT) begin
                r_saved_mode <= r_mode;
                r_saved_cnt  <= r_phase_cnt;
                r_mode       <= FRIGHT;
            end
        end
`endif
        else if (enable && startOfFrame) begin
            case (r_mode)
                IDLE: begin
                    r_mode      <= SCATTER;
                    r_phase_cnt <= '0;
                end
                SCATTER: begin
                    if (r_phase_cnt == CNT_W'(SCATTER_FRAMES - 1)) begin
                        r_mode      <= CHASE;
                        r_phase_cnt <= '0;
                    end else begin
                        r_phase_cnt <= r_phase_cnt + 1'b1;
                    end
                end
                CHASE: begin
                    if (r_phase_cnt == CNT_W'(CHASE_FRAMES - 1)) begin
                        r_mode      <= SCATTER;
                        r_phase_cnt <= '0;
                    end else begin
                        r_phase_cnt <= r_phase_cnt + 1'b1;
                    end
                end
`ifdef GHOST_FRIGHT_EN
                FRIGHT: begin
                    if (r_fright_cnt == CNT_W'(1)) begin
                        r_mode       <= r_saved_mode;
                        r_phase_cnt  <= r_saved_cnt;
                        r_frightened <= 1'b0;
                    end else begin
                        r_fright_cnt <= r_fright_cnt - 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        if (r_mode == CHASE) begin
            w_tx = {pacmanX[COORD_W-1], pacmanX};
            w_ty = {pacmanY[COORD_W-1], pacmanY};
        end else begin
            w_tx = SC_X;
            w_ty = SC_Y;
        end
        w_dx    = w_tx - {monsterX[COORD_W-1], monsterX};
        w_dy    = w_ty - {monsterY[COORD_W-1], monsterY};
        w_adx   = w_dx[COORD_W] ? -w_dx : w_dx;
        w_ady   = w_dy[COORD_W] ? -w_dy : w_dy;
        w_x_dir = w_dx[COORD_W] ? LEFT : RIGHT;
        w_y_dir = w_dy[COORD_W] ? UP : DOWN;
        if (w_adx >= w_ady) begin
            w_pri = w_x_dir;
            w_sec = w_y_dir;
        end else begin
            w_pri = w_y_dir;
            w_sec = w_x_dir;
        end
        if (r_coll) begin
            w_next_dir = (w_sec == r_dir) ? reverse(r_dir) : w_sec;
        end else if (w_pri == reverse(r_dir)) begin
            w_next_dir = w_sec;
        end else begin
            w_next_dir = w_pri;
        end
`ifdef GHOST_FRIGHT_EN
        if (r_mode == FRIGHT) begin
            if (r_coll) begin
                w_next_dir = reverse(r_dir);
            end else if (dir_t'(w_lfsr[1:0]) == reverse(r_dir)) begin
                w_next_dir = r_dir;
            end else begin
                w_next_dir = dir_t'(w_lfsr[1:0]);
            end
        end
`endif
    end

    // Decision FSM; the latch is refreshed every DECIDE so a frozen block still drops stale hits.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_dec_state <= DEC_WAIT;
            r_dir       <= dir_t'(INIT_DIR);
            r_hold      <= '0;
            r_coll      <= 1'b0;
        end else begin
            case (r_dec_state)
                DEC_WAIT: begin
                    r_coll <= r_coll | collision;
                    if (startOfFrame) begin
                        r_dec_state <= DEC_DECIDE;
                    end
                end
                DEC_DECIDE: begin
                    r_dec_state <= DEC_WAIT;
                    r_coll      <= collision;
                    if (enable) begin
                        if (r_hold == '0 || r_coll) begin
                            r_dir  <= w_next_dir;
                            r_hold <= HOLD_LOAD;
                        end else begin
                            r_hold <= r_hold - 1'b1;
                        end
                    end
                end
                default: r_dec_state <= DEC_WAIT;
            endcase
        end
    end

    assign direction_key = r_dir;
    assign mode          = r_mode;

endmodule

// File: tb/tb_monster_dir_ctrl.sv
// Self-checking bench for monster_dir_ctrl against a frame-level behavioural model.
module tb_monster_dir_ctrl;

    localparam int SCATTER_X      = 40;
    localparam int SCATTER_Y      = 40;
    localparam int SCATTER_FRAMES = 210;
    localparam int CHASE_FRAMES   = 600;
    localparam int FRIGHT_FRAMES  = 180;
    localparam int HOLD_FRAMES    = 8;
    localparam int GAP            = 5;
`ifdef GHOST_FRIGHT_EN
    localparam bit FRIGHT_ON = 1'b1;
`else
    localparam bit FRIGHT_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               resetN, startOfFrame, enable, collision, powerPill;
    logic signed [10:0] pacmanX, pacmanY, monsterX, monsterY;
    logic [1:0]         direction_key, mode;
    logic               frightened;

    int errors = 0;
    int checks = 0;

    // Model state: modes 0 idle, 1 scatter, 2 chase, 3 fright; dirs 0 up, 1 down, 2 right, 3 left.
    int       m_mode, m_phase, m_saved_mode, m_saved_phase, m_fright_left, m_dir, m_hold;
    bit       m_coll, m_decided;
    bit [7:0] m_lfsr;

    monster_dir_ctrl #(
        .SCATTER_X      (SCATTER_X),
        .SCATTER_Y      (SCATTER_Y),
        .SCATTER_FRAMES (SCATTER_FRAMES),
        .CHASE_FRAMES   (CHASE_FRAMES),
        .FRIGHT_FRAMES  (FRIGHT_FRAMES),
        .HOLD_FRAMES    (HOLD_FRAMES),
        .INIT_DIR       (2'b11),
        .LFSR_SEED      (8'hA5)
    ) u_dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .enable        (enable),
        .collision     (collision),
        .powerPill     (powerPill),
        .pacmanX       (pacmanX),
        .pacmanY       (pacmanY),
        .monsterX      (monsterX),
        .monsterY      (monsterY),
        .direction_key (direction_key),
        .mode          (mode),
        .frightened    (frightened)
    );

    always #5 clk = ~clk;

    function automatic int rev(input int d);
        return d ^ 1;
    endfunction

    function automatic bit [7:0] lfsr_next(input bit [7:0] s);
        return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int choose_dir(input int cur, input int md, input bit coll,
                                      input bit [7:0] lf, input int px, input int py,
                                      input int mx, input int my);
        int tx, ty, dx, dy, xd, yd, pri, sec, cand;
        tx = (md == 2) ? px : SCATTER_X;
        ty = (md == 2) ? py : SCATTER_Y;
        dx = tx - mx;
        dy = ty - my;
        xd = (dx >= 0) ? 2 : 3;
        yd = (dy >= 0) ? 1 : 0;
        pri = (iabs(dx) >= iabs(dy)) ? xd : yd;
        sec = (iabs(dx) >= iabs(dy)) ? yd : xd;
        if (md == 3) begin
            if (coll) return rev(cur);
            cand = int'(lf[1:0]);
            return (cand == rev(cur)) ? cur : cand;
        end
        if (coll) return (sec == cur) ? rev(cur) : sec;
        return (pri == rev(cur)) ? sec : pri;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_phase = 0; m_saved_mode = 0; m_saved_phase = 0; m_fright_left = 0;
        m_dir = 3; m_hold = 0; m_coll = 0; m_decided = 0; m_lfsr = 8'hA5;
    endtask

    task automatic model_pill(input bit en);
        if (en && FRIGHT_ON && m_mode != 0) begin
            if (m_mode != 3) begin
                m_saved_mode  = m_mode;
                m_saved_phase = m_phase;
                m_mode        = 3;
            end
            m_fright_left = FRIGHT_FRAMES;
        end
    endtask

    task automatic model_frame(input bit en, input bit pill_sof);
        m_decided = 1'b0;
        if (en) begin
            if (pill_sof && FRIGHT_ON && m_mode != 0) begin
                model_pill(1'b1);
            end else begin
                case (m_mode)
                    0: begin m_mode = 1; m_phase = 0; end
                    1: begin
                        m_phase++;
                        if (m_phase == SCATTER_FRAMES) begin m_mode = 2; m_phase = 0; end
                    end
                    2: begin
                        m_phase++;
                        if (m_phase == CHASE_FRAMES) begin m_mode = 1; m_phase = 0; end
                    end
                    default: begin
                        m_fright_left--;
                        if (m_fright_left == 0) begin m_mode = m_saved_mode; m_phase = m_saved_phase; end
                    end
                endcase
            end
            if (FRIGHT_ON) m_lfsr = lfsr_next(m_lfsr);
            m_decided = (m_hold == 0) || m_coll;
            if (m_decided) begin
                m_dir  = choose_dir(m_dir, m_mode, m_coll, m_lfsr, pacmanX, pacmanY, monsterX, monsterY);
                m_hold = HOLD_FRAMES - 1;
            end else begin
                m_hold--;
            end
        end
        m_coll = 1'b0;
    endtask

    // One frame: idle gap (optional collision/pill pulses), frame pulse, then the DECIDE edge.
    task automatic run_frame(input bit en, input bit coll, input bit pill_gap, input bit pill_sof);
        enable = en;
        repeat (2) @(negedge clk);
        if (coll) begin
            collision = 1'b1; @(negedge clk); collision = 1'b0;
            m_coll = 1'b1;
        end
        if (pill_gap) begin
            powerPill = 1'b1; @(negedge clk); powerPill = 1'b0;
            model_pill(en);
        end
        repeat (GAP) @(negedge clk);
        startOfFrame = 1'b1; powerPill = pill_sof;
        @(negedge clk);
        startOfFrame = 1'b0; powerPill = 1'b0;
        @(negedge clk);
        model_frame(en, pill_sof);
    endtask

    task automatic set_pos(input int px, input int py, input int mx, input int my);
        pacmanX = 11'(px); pacmanY = 11'(py); monsterX = 11'(mx); monsterY = 11'(my);
    endtask

    task automatic test_reset();
        resetN = 1'b0; startOfFrame = 1'b0; enable = 1'b1; collision = 1'b0; powerPill = 1'b0;
        set_pos(300, 200, 500, 200);
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (mode !== 2'b00 || direction_key !== 2'b11 || frightened !== 1'b0) begin
            errors++;
            $display("FAIL reset: mode/dir/fr=%0d/%0d/%0b required 0/3/0", mode, direction_key, frightened);
        end
        resetN = 1'b1;
        run_frame(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (mode !== 2'b01) begin
            errors++;
            $display("FAIL first_frame_mode: mode=%0d required 1", mode);
        end
        checks++;
        if (direction_key !== 2'b11) begin
            errors++;
            $display("FAIL first_decision: dir=%0d required 3", direction_key);
        end
    endtask

    task automatic test_mode_timing();
        logic [1:0] exp_mode;
        for (int f = 2; f <= 811; f++) begin
            run_frame(1'b1, 1'b0, 1'b0, 1'b0);
            checks++;
            if (mode !== 2'(m_mode) || direction_key !== 2'(m_dir)) begin
                errors++;
                $display("FAIL timing_model frame %0d: mode/dir=%0d/%0d required %0d/%0d",
                         f, mode, direction_key, m_mode, m_dir);
            end
            if (f == 210 || f == 211 || f == 810 || f == 811) begin
                exp_mode = (f == 211 || f == 810) ? 2'b10 : 2'b01;
                checks++;
                if (mode !== exp_mode) begin
                    errors++;
                    $display("FAIL phase_switch frame %0d: mode=%0d required %0d", f, mode, exp_mode);
                end
            end
        end
    endtask

    task automatic test_reverse_forbidden();
        bit done = 1'b0;
        set_pos(40, 40, 0, 40);
        for (int i = 0; i < 40 && !done; i++) begin
            run_frame(1'b1, 1'b0, 1'b0, 1'b0);
            if (m_decided && m_dir == 2) done = 1'b1;
        end
        checks++;
        if (!done || direction_key !== 2'b10) begin
            errors++;
            $display("FAIL setup_right: dir=%0d required 2 (reached=%0b)", direction_key, done);
        end
        set_pos(40, 40, 90, 30);
        done = 1'b0;
        for (int i = 0; i < HOLD_FRAMES && !done; i++) begin
            run_frame(1'b1, 1'b0, 1'b0, 1'b0);
            done = m_decided;
        end
        checks++;
        if (!done || direction_key !== 2'b01) begin
            errors++;
            $display("FAIL reverse_forbidden: dir=%0d required 1 (decided=%0b)", direction_key, done);
        end
    endtask

    task automatic test_collision();
        bit done = 1'b0;
        set_pos(40, 40, 200, 40);
        for (int i = 0; i < 40 && !done; i++) begin
            run_frame(1'b1, 1'b0, 1'b0, 1'b0);
            if (m_decided && m_dir == 3) done = 1'b1;
        end
        checks++;
        if (!done || direction_key !== 2'b11) begin
            errors++;
            $display("FAIL setup_left: dir=%0d required 3 (reached=%0b)", direction_key, done);
        end
        set_pos(40, 40, 200, 60);
        run_frame(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (direction_key !== 2'b00) begin
            errors++;
            $display("FAIL collision_turn: dir=%0d required 0", direction_key);
        end
    endtask

    task automatic test_random();
        bit en, coll, pg, ps;
        for (int i = 0; i < 300; i++) begin
            set_pos($urandom_range(0, 700), $urandom_range(0, 500),
                    $urandom_range(0, 700), $urandom_range(0, 500));
            en   = ($urandom_range(0, 7) != 0);
            coll = ($urandom_range(0, 3) == 0);
            pg   = ($urandom_range(0, 60) == 0);
            ps   = ($urandom_range(0, 80) == 0);
            run_frame(en, coll, pg, ps);
            checks++;
            if (mode !== 2'(m_mode) || direction_key !== 2'(m_dir) || frightened !== (m_mode == 3)) begin
                errors++;
                $display("FAIL random frame %0d: mode/dir/fr=%0d/%0d/%0b required %0d/%0d/%0b",
                         i, mode, direction_key, frightened, m_mode, m_dir, m_mode == 3);
            end
        end
    endtask

`ifdef GHOST_FRIGHT_EN
    task automatic test_fright();
        bit found = 1'b0;
        logic [1:0] exp_mode;
        set_pos(300, 200, 100, 100);
        for (int i = 0; i < 2000 && !found; i++) begin
            if (m_mode == 2 && m_phase == 100) found = 1'b1;
            else run_frame(1'b1, 1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL chase_100_timeout: mode=%0d required 2", mode);
        end
        for (int f = 1; f <= 680; f++) begin
            set_pos(300, 200, $urandom_range(0, 600), $urandom_range(0, 400));
            run_frame(1'b1, 1'b0, f == 1, 1'b0);
            exp_mode = (f < 180) ? 2'b11 : ((f < 680) ? 2'b10 : 2'b01);
            checks++;
            if (mode !== exp_mode || frightened !== (f < 180) || direction_key !== 2'(m_dir)) begin
                errors++;
                $display("FAIL fright_resume frame %0d: mode/fr/dir=%0d/%0b/%0d required %0d/%0b/%0d",
                         f, mode, frightened, direction_key, exp_mode, f < 180, m_dir);
            end
        end
        for (int f = 1; f <= 270; f++) begin
            run_frame(1'b1, ($urandom_range(0, 5) == 0), f == 1 || f == 91, 1'b0);
            exp_mode = (f < 270) ? 2'b11 : 2'b01;
            checks++;
            if (mode !== exp_mode || frightened !== (f < 270) || direction_key !== 2'(m_dir)) begin
                errors++;
                $display("FAIL fright_extend frame %0d: mode/fr/dir=%0d/%0b/%0d required %0d/%0b/%0d",
                         f, mode, frightened, direction_key, exp_mode, f < 270, m_dir);
            end
        end
    endtask
`endif

    task automatic test_reset_mid_and_pill_sof();
        logic [1:0] exp_mode;
        run_frame(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (3) run_frame(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2 resetN = 1'b0;
        #1;
        checks++;
        if (mode !== 2'b00 || direction_key !== 2'b11 || frightened !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: mode/dir/fr=%0d/%0d/%0b required 0/3/0", mode, direction_key, frightened);
        end
        @(negedge clk);
        resetN = 1'b1;
        model_reset();
        set_pos(300, 200, 500, 200);
        run_frame(1'b1, 1'b0, 1'b0, 1'b0);
        run_frame(1'b1, 1'b0, 1'b0, 1'b1);
        exp_mode = FRIGHT_ON ? 2'b11 : 2'b01;
        checks++;
        if (mode !== exp_mode) begin
            errors++;
            $display("FAIL pill_sof_mode: mode=%0d required %0d", mode, exp_mode);
        end
        for (int f = 1; f <= 392; f++) begin
            run_frame(1'b1, 1'b0, 1'b0, 1'b0);
            checks++;
            if (mode !== 2'(m_mode) || direction_key !== 2'(m_dir)) begin
                errors++;
                $display("FAIL pill_sof_model frame %0d: mode/dir=%0d/%0d required %0d/%0d",
                         f, mode, direction_key, m_mode, m_dir);
            end
            if (f == 179 || f == 389) begin
                exp_mode = (f == 179) ? (FRIGHT_ON ? 2'b11 : 2'b01) : (FRIGHT_ON ? 2'b01 : 2'b10);
                checks++;
                if (mode !== exp_mode) begin
                    errors++;
                    $display("FAIL pill_sof_uncounted frame %0d: mode=%0d required %0d", f, mode, exp_mode);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode_timing();
        test_reverse_forbidden();
        test_collision();
        test_random();
`ifdef GHOST_FRIGHT_EN
        test_fright();
`endif
        test_reset_mid_and_pill_sof();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
